lcd_char_responder: RTL and testbench

- Responder end of the HD44780-style 8-bit character-LCD bus (lcd_e/lcd_rs/lcd_rw/lcd_data) that our LCD-writing blocks drive.
- Decodes instructions and data writes, and maintains a 2x16 DDRAM, address counter (AC), mode bits and busy flag.
- Exposes a DDRAM scan port for an on-chip display renderer or bench checker.
- Used as an in-fabric LCD emulator and as the verification target for LCD drivers.

---
 rtl/lcd_char_responder_if.sv | 20 ++
 rtl/lcd_char_responder.sv | 196 +++++++++++++++++++
 tb/tb_lcd_char_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_char_responder_if.sv
// HD44780-style 8-bit character-LCD bus between an LCD driver (master) and
// the responder/emulator (slave).
interface lcd_char_responder_if;
   logic       lcd_e;
   logic       lcd_rs;
   logic       lcd_rw;
   logic [7:0] lcd_data_in;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;

   modport master (
      output lcd_e, lcd_rs, lcd_rw, lcd_data_in,
      input  lcd_data_out, lcd_data_oe
   );

   modport slave (
      input  lcd_e, lcd_rs, lcd_rw, lcd_data_in,
      output lcd_data_out, lcd_data_oe
   );
endinterface

// File: rtl/lcd_char_responder.sv
// Responder end of an HD44780-style character-LCD bus: 2x16 DDRAM, address
// counter, display/cursor bits, busy flag and a registered DDRAM scan port.
// Optional macro LCD_READ_EN enables bus reads (busy/AC and DDRAM data).
module lcd_char_responder #(
   parameter int unsigned BUSY_CYC  = 4,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                  clk,
   input  logic                  rst,
   lcd_char_responder_if.slave   lcd,
   output logic                  busy,
   output logic                  disp_on,
   output logic                  cursor_on,
   input  logic [4:0]            scan_addr,
   output logic [7:0]            scan_char,
   output logic                  overrun
);

   localparam int unsigned CntW = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      clr_idx_q, clr_idx_d;
   logic [6:0]      ac_q, ac_d;
   // Shift (S) and blink (B) have no observable effect here, so only I/D, D, C are kept.
   logic            id_q, id_d;
   logic            disp_q, disp_d;
   logic            cur_q, cur_d;
   logic            overrun_q, overrun_d;
   logic [7:0]      scan_char_q, scan_char_d;
   logic            e_meta_q, e_meta_d, e_sync_q, e_sync_d, e_prev_q, e_prev_d;
   logic            cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
   logic [7:0]      cap_data_q, cap_data_d;

   logic [7:0]      mem_q [32];
   logic            wr_en;
   logic [4:0]      wr_idx;
   logic [7:0]      wr_data;
   logic            commit, accept;
   logic [4:0]      ac_idx;

   // Step the address counter across the two 16-cell lines.
   function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] r;
      if (inc) begin
         if (ac == 7'h0F)      r = 7'h40;
         else if (ac == 7'h4F) r = 7'h00;
         else                  r = ac + 7'd1;
      end else begin
         if (ac == 7'h00)      r = 7'h4F;
         else if (ac == 7'h40) r = 7'h0F;
         else                  r = ac - 7'd1;
      end
      return r;
   endfunction

   assign ac_idx = {ac_q[6], ac_q[3:0]};
   assign commit = e_prev_q & ~e_sync_q;

`ifdef LCD_READ_EN
   // Busy-flag reads are always serviced and never count as a real access.
   assign accept = commit & ~(cap_rw_q & ~cap_rs_q);
   assign lcd.lcd_data_oe  = e_sync_q & lcd.lcd_rw;
   assign lcd.lcd_data_out = !lcd.lcd_data_oe ? 8'h00 :
                             lcd.lcd_rs ? mem_q[ac_idx] : {busy, ac_q};
`else
   // Reads are invisible: no busy, no overrun.
   assign accept = commit & ~cap_rw_q;
   assign lcd.lcd_data_oe  = 1'b0;
   assign lcd.lcd_data_out = 8'h00;
`endif

   assign busy      = (state_q != S_IDLE);
   assign disp_on   = disp_q;
   assign cursor_on = cur_q;
   assign overrun   = overrun_q;
   assign scan_char = scan_char_q;

   // Synchronizer, bus capture and scan-port next state.
   always_comb begin
      e_meta_d    = lcd.lcd_e;
      e_sync_d    = e_meta_q;
      e_prev_d    = e_sync_q;
      cap_rs_d    = e_sync_q ? lcd.lcd_rs      : cap_rs_q;
      cap_rw_d    = e_sync_q ? lcd.lcd_rw      : cap_rw_q;
      cap_data_d  = e_sync_q ? lcd.lcd_data_in : cap_data_q;
      scan_char_d = mem_q[scan_addr];
   end

   // FSM next state, access execution and DDRAM write port.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      clr_idx_d = clr_idx_q;
      ac_d      = ac_q;
      id_d      = id_q;
      disp_d    = disp_q;
      cur_d     = cur_q;
      overrun_d = overrun_q;
      wr_en     = 1'b0;
      wr_idx    = ac_idx;
      wr_data   = cap_data_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_BUSY;
               cnt_d   = CntW'(BUSY_CYC - 1);
               if (cap_rs_q) begin
                  // Data write, or DDRAM read when reads are enabled.
                  wr_en = ~cap_rw_q;
                  ac_d  = ac_step(ac_q, id_q);
               end else if (cap_data_q[7]) begin
                  ac_d = {cap_data_q[6], 2'b00, cap_data_q[3:0]};
               end else if (cap_data_q[6] || cap_data_q[5]) begin
                  // CGRAM address / function set: busy only.
               end else if (cap_data_q[4]) begin
                  if (!cap_data_q[3]) ac_d = ac_step(ac_q, cap_data_q[2]);
               end else if (cap_data_q[3]) begin
                  disp_d = cap_data_q[2];
                  cur_d  = cap_data_q[1];
               end else if (cap_data_q[2]) begin
                  id_d = cap_data_q[1];
               end else if (cap_data_q[1]) begin
                  ac_d = 7'h00;
               end else if (cap_data_q[0]) begin
                  state_d   = S_CLEAR;
                  clr_idx_d = 5'd0;
               end
            end
         end
         S_BUSY: begin
            if (accept) overrun_d = 1'b1;
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         S_CLEAR: begin
            if (accept) overrun_d = 1'b1;
            wr_en     = 1'b1;
            wr_idx    = clr_idx_q;
            wr_data   = FILL_CHAR;
            clr_idx_d = clr_idx_q + 5'd1;
            if (clr_idx_q == 5'd31) begin
               state_d = S_IDLE;
               ac_d    = 7'h00;
               id_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset lands in S_CLEAR so DDRAM gets filled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_CLEAR;
         cnt_q       <= '0;
         clr_idx_q   <= 5'd0;
         ac_q        <= 7'h00;
         id_q        <= 1'b1;
         disp_q      <= 1'b0;
         cur_q       <= 1'b0;
         overrun_q   <= 1'b0;
         scan_char_q <= 8'h00;
         e_meta_q    <= 1'b0;
         e_sync_q    <= 1'b0;
         e_prev_q    <= 1'b0;
         cap_rs_q    <= 1'b0;
         cap_rw_q    <= 1'b0;
         cap_data_q  <= 8'h00;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         clr_idx_q   <= clr_idx_d;
         ac_q        <= ac_d;
         id_q        <= id_d;
         disp_q      <= disp_d;
         cur_q       <= cur_d;
         overrun_q   <= overrun_d;
         scan_char_q <= scan_char_d;
         e_meta_q    <= e_meta_d;
         e_sync_q    <= e_sync_d;
         e_prev_q    <= e_prev_d;
         cap_rs_q    <= cap_rs_d;
         cap_rw_q    <= cap_rw_d;
         cap_data_q  <= cap_data_d;
      end
   end

   // DDRAM storage; contents are initialised by the clear sequence, not reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

endmodule

// File: tb/tb_lcd_char_responder.sv
// Self-checking bench for lcd_char_responder: table of bus accesses with
// DDRAM scan checks through an expected-value queue, plus hand-written
// sequences for reset/clear timing, overrun and the read path.
module tb_lcd_char_responder;

   logic       clk = 1'b0;
   logic       rst;
   logic       busy, disp_on, cursor_on, overrun;
   logic [4:0] scan_addr;
   logic [7:0] scan_char;

   lcd_char_responder_if bus ();

   lcd_char_responder #(.BUSY_CYC(4), .FILL_CHAR(8'h20)) dut (
      .clk       (clk),
      .rst       (rst),
      .lcd       (bus),
      .busy      (busy),
      .disp_on   (disp_on),
      .cursor_on (cursor_on),
      .scan_addr (scan_addr),
      .scan_char (scan_char),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] exp_q [$];

   typedef struct {
      logic       rs;
      logic [7:0] data;
      logic       chk;
      logic [4:0] addr;
      logic [7:0] val;
      logic       disp;
      logic       cur;
   } vec_t;

   vec_t tbl [$];

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Queue the expected cell value, then compare once the registered scan output appears.
   task automatic scan_check(input string name, input logic [4:0] a, input logic [7:0] e);
      logic [7:0] want;
      scan_addr = a;
      exp_q.push_back(e);
      @(negedge clk);
      want = exp_q.pop_front();
      cmp(name, {24'h0, scan_char}, {24'h0, want});
   endtask

   task automatic access(input logic rs, input logic rw, input logic [7:0] data);
      bus.lcd_rs      = rs;
      bus.lcd_rw      = rw;
      bus.lcd_data_in = data;
      bus.lcd_e       = 1'b1;
      repeat (3) @(negedge clk);
      bus.lcd_e       = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      repeat (4) @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      cmp(name, {31'h0, busy}, 32'h0);
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!busy && n < 10) begin
         @(negedge clk);
         n++;
      end
      cmp(name, {31'h0, busy}, 32'h1);
   endtask

   task automatic count_busy(input string name, input int exp_len);
      int n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      cmp(name, n, exp_len);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b0;
      bus.lcd_e       = 1'b0;
      bus.lcd_rs      = 1'b0;
      bus.lcd_rw      = 1'b0;
      bus.lcd_data_in = 8'h00;
      scan_addr       = 5'd0;

      //         rs  data   chk addr   val    disp cur
      tbl.push_back('{1'b0, 8'h0C, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h31, 1'b1, 5'd0,  8'h31, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h2B, 1'b1, 5'd1,  8'h2B, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h32, 1'b1, 5'd2,  8'h32, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h33, 1'b1, 5'd3,  8'h33, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h8F, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h41, 1'b1, 5'd15, 8'h41, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h42, 1'b1, 5'd16, 8'h42, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h44, 1'b1, 5'd17, 8'h44, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'hCF, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h43, 1'b1, 5'd31, 8'h43, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 8'h45, 1'b1, 5'd0,  8'h45, 1'b1, 1'b0});
      tbl.push_back('{1'b0, 8'h0E, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h04, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h80, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h5A, 1'b1, 5'd0,  8'h5A, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h14, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h5C, 1'b1, 5'd0,  8'h5C, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h5B, 1'b1, 5'd31, 8'h5B, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h10, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h5D, 1'b1, 5'd29, 8'h5D, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h06, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h18, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h5E, 1'b1, 5'd28, 8'h5E, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h02, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h60, 1'b1, 5'd0,  8'h60, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h38, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h40, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h61, 1'b1, 5'd1,  8'h61, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h9A, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h62, 1'b1, 5'd10, 8'h62, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'hFC, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1});
      tbl.push_back('{1'b1, 8'h63, 1'b1, 5'd28, 8'h63, 1'b1, 1'b1});
      tbl.push_back('{1'b0, 8'h0A, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1});

      // Reset state.
      repeat (3) @(negedge clk);
      cmp("rst_busy", {31'h0, busy}, 32'h1);
      cmp("rst_oe", {31'h0, bus.lcd_data_oe}, 32'h0);
      cmp("rst_dout", {24'h0, bus.lcd_data_out}, 32'h0);
      cmp("rst_overrun", {31'h0, overrun}, 32'h0);
      cmp("rst_scan", {24'h0, scan_char}, 32'h0);
      cmp("rst_disp", {31'h0, disp_on}, 32'h0);
      cmp("rst_cursor", {31'h0, cursor_on}, 32'h0);

      // Power-up clear lasts 32 cycles and fills every cell.
      rst = 1'b1;
      count_busy("rst_clear_len", 32);
      for (int i = 0; i < 32; i++) scan_check("rst_fill", 5'(i), 8'h20);

      // Table-driven accesses.
      foreach (tbl[i]) begin
         access(tbl[i].rs, 1'b0, tbl[i].data);
         wait_idle("vec_idle");
         cmp("vec_disp", {31'h0, disp_on}, {31'h0, tbl[i].disp});
         cmp("vec_cursor", {31'h0, cursor_on}, {31'h0, tbl[i].cur});
         cmp("vec_overrun", {31'h0, overrun}, 32'h0);
         if (tbl[i].chk) scan_check("vec_cell", tbl[i].addr, tbl[i].val);
      end

      // Write arriving one cycle after the previous commit is dropped. AC is 0x4D here.
      access(1'b1, 1'b0, 8'h70);
      wait_busy("ovr_busy_rise");
      bus.lcd_data_in = 8'h71;
      bus.lcd_e       = 1'b1;
      @(negedge clk);
      bus.lcd_e       = 1'b0;
      repeat (4) @(negedge clk);
      cmp("ovr_flag", {31'h0, overrun}, 32'h1);
      wait_idle("ovr_idle");
      scan_check("ovr_prev_cell", 5'd29, 8'h70);
      scan_check("ovr_dropped", 5'd30, 8'h20);
      access(1'b1, 1'b0, 8'h72);
      wait_idle("ovr_next_idle");
      scan_check("ovr_ac_kept", 5'd30, 8'h72);

      // Clear command: 32 busy cycles, every cell refilled, overrun stays set.
      access(1'b0, 1'b0, 8'h01);
      wait_busy("clr_busy_rise");
      count_busy("clr_len", 32);
      for (int i = 0; i < 32; i++) scan_check("clr_fill", 5'(i), 8'h20);
      cmp("clr_overrun", {31'h0, overrun}, 32'h1);
      access(1'b1, 1'b0, 8'h73);
      wait_idle("clr_after_idle");
      scan_check("clr_ac_home", 5'd0, 8'h73);
      access(1'b1, 1'b0, 8'h74);
      wait_idle("clr_id_idle");
      scan_check("clr_id_inc", 5'd1, 8'h74);

      // Read path.
      access(1'b0, 1'b0, 8'hC2);
      wait_idle("rd_setup_idle");
`ifdef LCD_READ_EN
      access(1'b1, 1'b0, 8'h7A);
      wait_idle("rd_wr_idle");
      scan_check("rd_cell18", 5'd18, 8'h7A);
      access(1'b0, 1'b0, 8'hC2);
      wait_idle("rd_ac_idle");
      bus.lcd_rs = 1'b0;
      bus.lcd_rw = 1'b1;
      bus.lcd_e  = 1'b1;
      repeat (3) @(negedge clk);
      cmp("rd_bf_oe", {31'h0, bus.lcd_data_oe}, 32'h1);
      cmp("rd_bf_data", {24'h0, bus.lcd_data_out}, 32'h42);
      bus.lcd_e  = 1'b0;
      repeat (4) @(negedge clk);
      cmp("rd_bf_nobusy", {31'h0, busy}, 32'h0);
      bus.lcd_rs = 1'b1;
      bus.lcd_e  = 1'b1;
      repeat (3) @(negedge clk);
      cmp("rd_dd_oe", {31'h0, bus.lcd_data_oe}, 32'h1);
      cmp("rd_dd_data", {24'h0, bus.lcd_data_out}, 32'h7A);
      bus.lcd_e  = 1'b0;
      repeat (4) @(negedge clk);
      cmp("rd_dd_busy", {31'h0, busy}, 32'h1);
      wait_idle("rd_dd_idle");
      cmp("rd_oe_off", {31'h0, bus.lcd_data_oe}, 32'h0);
      access(1'b1, 1'b0, 8'h7B);
      wait_idle("rd_next_idle");
      scan_check("rd_ac_step", 5'd19, 8'h7B);
`else
      bus.lcd_rs = 1'b1;
      bus.lcd_rw = 1'b1;
      bus.lcd_e  = 1'b1;
      repeat (3) @(negedge clk);
      cmp("rd_oe_off", {31'h0, bus.lcd_data_oe}, 32'h0);
      cmp("rd_dout_zero", {24'h0, bus.lcd_data_out}, 32'h0);
      bus.lcd_e  = 1'b0;
      repeat (4) @(negedge clk);
      cmp("rd_nobusy", {31'h0, busy}, 32'h0);
      access(1'b1, 1'b0, 8'h7B);
      wait_idle("rd_next_idle");
      scan_check("rd_ac_kept", 5'd18, 8'h7B);
`endif
      cmp("end_overrun", {31'h0, overrun}, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
